seg_display: RTL and testbench

SEG_DISPLAY -- requirements
Module: seg_display

---
 rtl/seg_display.sv | 97 +++++++++
 tb/tb_seg_display.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_display.sv
// Four-digit multiplexed seven-segment driver with value freeze and PC LED mirror.
// Optional leading-zero blanking is enabled with the macro SEG_LEADING_ZERO_BLANK_EN.
module seg_display #(
  parameter logic [15:0] REFRESH_DIV = 16'd50000
) (
  input  logic        clk,
  input  logic        reset_cpu_n,
  input  logic [15:0] data_in,
  input  logic [7:0]  pc_in,
  input  logic        freeze,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [7:0]  led
);

  // A divisor of zero behaves as one: terminal count is then 0 every cycle.
  localparam logic [15:0] LAST = (REFRESH_DIV == 16'd0) ? 16'd0 : REFRESH_DIV - 16'd1;

  logic [15:0] cnt;
  logic [1:0]  idx;
  logic [15:0] shown;
  logic [3:0]  nib;
  logic [6:0]  seg_hex;
  logic        blank;

  always_ff @(posedge clk or negedge reset_cpu_n) begin
    if (!reset_cpu_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_cpu_n) begin
    if (!reset_cpu_n) begin
      shown <= '0;
      led   <= '0;
    end else begin
      if (!freeze) shown <= data_in;
      led <= pc_in;
    end
  end

  always_comb begin
    nib = shown[{idx, 2'b00} +: 4];
    case (nib)
      4'h0: seg_hex = 7'b0000001;
      4'h1: seg_hex = 7'b1001111;
      4'h2: seg_hex = 7'b0010010;
      4'h3: seg_hex = 7'b0000110;
      4'h4: seg_hex = 7'b1001100;
      4'h5: seg_hex = 7'b0100100;
      4'h6: seg_hex = 7'b0100000;
      4'h7: seg_hex = 7'b0001111;
      4'h8: seg_hex = 7'b0000000;
      4'h9: seg_hex = 7'b0000100;
      4'hA: seg_hex = 7'b0001000;
      4'hB: seg_hex = 7'b1100000;
      4'hC: seg_hex = 7'b0110001;
      4'hD: seg_hex = 7'b1000010;
      4'hE: seg_hex = 7'b0110000;
      default: seg_hex = 7'b0111000;
    endcase
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // Digit k is blank when it and every digit to its left are zero; digit 0 always shows.
  always_comb begin
    case (idx)
      2'd3:    blank = (shown[15:12] == 4'h0);
      2'd2:    blank = (shown[15:8] == 8'h00);
      2'd1:    blank = (shown[15:4] == 12'h000);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_cpu_n) begin
    if (!reset_cpu_n) begin
      an  <= 4'b1110;
      seg <= 7'b0000001;
      dp  <= 1'b1;
    end else begin
      an  <= ~(4'b0001 << idx);
      seg <= blank ? 7'b1111111 : seg_hex;
      dp  <= ~(freeze && (idx == 2'd3));
    end
  end

endmodule

// File: tb/tb_seg_display.sv
// Randomized bench for seg_display: a cycle-count scan model checks three divisor
// variants every cycle, plus literal checks for decode, freeze, blanking and reset.
module tb_seg_display;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] data_in = '0;
  logic [7:0]  pc_in = '0;
  logic        freeze = 1'b0;

  logic [3:0] an_d  [3];
  logic [6:0] seg_d [3];
  logic       dp_d  [3];
  logic [7:0] led_d [3];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seg_display #(.REFRESH_DIV(16'd4)) dut0 (
    .clk(clk), .reset_cpu_n(rst_n), .data_in(data_in), .pc_in(pc_in), .freeze(freeze),
    .an(an_d[0]), .seg(seg_d[0]), .dp(dp_d[0]), .led(led_d[0]));
  seg_display #(.REFRESH_DIV(16'd1)) dut1 (
    .clk(clk), .reset_cpu_n(rst_n), .data_in(data_in), .pc_in(pc_in), .freeze(freeze),
    .an(an_d[1]), .seg(seg_d[1]), .dp(dp_d[1]), .led(led_d[1]));
  seg_display #(.REFRESH_DIV(16'd0)) dut2 (
    .clk(clk), .reset_cpu_n(rst_n), .data_in(data_in), .pc_in(pc_in), .freeze(freeze),
    .an(an_d[2]), .seg(seg_d[2]), .dp(dp_d[2]), .led(led_d[2]));

  logic [6:0] hex_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  // Model: edges since release decide the digit; outputs show the state before the edge.
  int          divs [3] = '{4, 1, 1};
  int          m_k [3];
  logic [15:0] m_shown [3];
  logic [3:0]  e_an  [3];
  logic [6:0]  e_seg [3];
  logic        e_dp  [3];
  logic [7:0]  e_led [3];

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_k[i] = 0; m_shown[i] = '0; e_an[i] = 4'b1110; e_seg[i] = 7'b0000001;
      e_dp[i] = 1'b1; e_led[i] = '0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      for (int i = 0; i < 3; i++) begin
        if (!rst_n) begin
          m_k[i] = 0; m_shown[i] = '0; e_an[i] = 4'b1110; e_seg[i] = 7'b0000001;
          e_dp[i] = 1'b1; e_led[i] = '0;
        end else begin
          int d;
          logic [3:0] nb;
          d = (m_k[i] / divs[i]) % 4;
          nb = 4'((m_shown[i] >> (4 * d)) & 16'hF);
          e_an[i] = ~(4'b0001 << d);
          e_seg[i] = hex_tab[nb];
`ifdef SEG_LEADING_ZERO_BLANK_EN
          if (d >= 1 && (m_shown[i] >> (4 * d)) == 0) e_seg[i] = 7'b1111111;
`endif
          e_dp[i] = !(freeze && d == 3);
          e_led[i] = pc_in;
          if (!freeze) m_shown[i] = data_in;
          m_k[i] = m_k[i] + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("model_an[%0d]", i), 16'(an_d[i]), 16'(e_an[i]));
        chk($sformatf("model_seg[%0d]", i), 16'(seg_d[i]), 16'(e_seg[i]));
        chk($sformatf("model_dp[%0d]", i), 16'(dp_d[i]), 16'(e_dp[i]));
        chk($sformatf("model_led[%0d]", i), 16'(led_d[i]), 16'(e_led[i]));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  // Wait (bounded) at negedges until dut0 shows the given anode pattern.
  task automatic wait_an(input logic [3:0] target, input string name);
    bit found = 0;
    for (int t = 0; t < 40 && !found; t++) begin
      @(negedge clk);
      if (an_d[0] == target) found = 1;
    end
    if (!found) chk({name, "_timeout"}, 16'(an_d[0]), 16'(target));
  endtask

  task automatic check_digit(input int d, input logic [6:0] exp, input string name);
    wait_an(~(4'b0001 << d), name);
    chk(name, 16'(seg_d[0]), 16'(exp));
  endtask

  initial begin
    #1 rst_n = 1'b0;
    cyc(3);
    chk("reset_an", 16'(an_d[0]), 16'h000E);
    chk("reset_seg", 16'(seg_d[0]), 16'h0001);
    chk("reset_dp", 16'(dp_d[0]), 16'h0001);
    chk("reset_led", 16'(led_d[0]), 16'h0000);
    rst_n = 1'b1;

    // Scan order after release: 4 cycles per digit, then wrap.
    for (int s = 0; s < 20; s++) begin
      @(negedge clk);
      chk("scan_an", 16'(an_d[0]), 16'(~(4'b0001 << ((s / 4) % 4)) & 4'hF));
    end

    data_in = 16'h1A2F;
    cyc(20);
    check_digit(0, 7'b0111000, "dec_d0");
    check_digit(1, 7'b0010010, "dec_d1");
    check_digit(2, 7'b0001000, "dec_d2");
    check_digit(3, 7'b1001111, "dec_d3");

    data_in = 16'h0050;
    cyc(20);
    check_digit(0, 7'b0000001, "blank_d0");
    check_digit(1, 7'b0100100, "blank_d1");
`ifdef SEG_LEADING_ZERO_BLANK_EN
    check_digit(2, 7'b1111111, "blank_d2");
    check_digit(3, 7'b1111111, "blank_d3");
`else
    check_digit(2, 7'b0000001, "blank_d2");
    check_digit(3, 7'b0000001, "blank_d3");
`endif

    data_in = 16'h1234;
    cyc(20);
    freeze = 1'b1; data_in = 16'hFFFF;
    for (int s = 0; s < 16; s++) begin
      int d;
      @(negedge clk);
      d = (an_d[0] == 4'b1110) ? 0 : (an_d[0] == 4'b1101) ? 1 : (an_d[0] == 4'b1011) ? 2 : 3;
      chk("frz_seg", 16'(seg_d[0]), 16'(hex_tab[4'((16'h1234 >> (4 * d)) & 16'hF)]));
      chk("frz_dp", 16'(dp_d[0]), (an_d[0] == 4'b0111) ? 16'h0 : 16'h1);
    end
    #1 freeze = 1'b0;
    cyc(18);
    for (int d = 0; d < 4; d++) check_digit(d, 7'b0111000, "unfrz_F");

    pc_in = 8'h15; freeze = 1'b0;
    cyc(1);
    chk("led_nofrz", 16'(led_d[0]), 16'h0015);
    pc_in = 8'hA7; freeze = 1'b1;
    cyc(1);
    chk("led_frz", 16'(led_d[0]), 16'h00A7);
    freeze = 1'b0;

    // Asynchronous reset mid-scan, observed before the next edge.
    wait_an(4'b1011, "midrst_wait");
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_an", 16'(an_d[0]), 16'h000E);
    chk("midrst_seg", 16'(seg_d[0]), 16'h0001);
    cyc(2);
    rst_n = 1'b1;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk("midrst_restart", 16'(an_d[0]), (s < 4) ? 16'h000E : 16'h000D);
    end

    // Randomized phase with occasional freeze changes and resets.
    for (int s = 0; s < 600; s++) begin
      cyc(1);
      data_in = 16'($urandom);
      if ($urandom_range(0, 3) == 0) data_in = 16'($urandom_range(0, 255));
      pc_in = 8'($urandom);
      if ($urandom_range(0, 3) == 0) freeze = ~freeze;
      if ($urandom_range(0, 149) == 0) begin
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
      end
    end
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
